chu_vga_fade_core: RTL

//  Frame-synchronous brightness fader for one slot of the video daisy chain.
//  - Scales every pixel of si_rgb by a level L/16, L in 0..16, and drives so_rgb.
//  - L steps by one every STEP frames, so firmware can fade to black or back

---
 rtl/chu_vga_fade_core.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/chu_vga_fade_core.sv
// Frame-synchronous brightness fader for one video chain slot: scales each
// pixel by L/LVL_MAX and ramps L one level every STEP frames on command.
module chu_vga_fade_core #(
  parameter int CD      = 12,
  parameter int LVL_MAX = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [10:0]                x,
  input  logic [10:0]                y,
  input  logic                       cs,
  input  logic                       write,
  input  logic [13:0]                addr,
  input  logic [31:0]                wr_data,
  input  logic [CD-1:0]              si_rgb,
  output logic [CD-1:0]              so_rgb,
  output logic [1:0]                 o_dbg_state,
  output logic [$clog2(LVL_MAX):0]   o_dbg_level,
  output logic                       o_dbg_tick
);

  localparam int SH = $clog2(LVL_MAX);
  localparam int LW = SH + 1;
  localparam int CW = CD / 3;
  localparam int PW = CW + LW;
  localparam logic [LW-1:0] L_FULL = LW'(LVL_MAX);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_FADE_OUT = 2'd1,
    S_FADE_IN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [LW-1:0]   r_lvl;
  logic [7:0]      r_cnt;
  logic [7:0]      r_step;
  logic            r_en;
  logic            r_at_origin;
  logic            r_tick_q;
  logic [CD-1:0]   r_s1_rgb;
  logic [LW-1:0]   r_s1_lvl;

  state_t          w_state_nxt;
  logic [LW-1:0]   w_lvl_nxt;
  logic [7:0]      w_cnt_nxt;
  logic [7:0]      w_step_nxt;
  logic            w_en_nxt;
  logic            w_wr;
  logic            w_origin;
  logic            w_tick;
  logic [7:0]      w_step_eff;
  logic            w_step_done;
  logic [LW-1:0]   w_lvl_wr;
  logic [CD-1:0]   w_scaled;
  logic            w_unused_bits;

  // Slot bus: a write is cs & write in one cycle, no backpressure; the
  // addressed register updates on that same clock edge.
  assign w_wr          = cs & write;
  assign w_unused_bits = &{1'b0, addr[13:2], wr_data[31:8]};

  assign w_origin    = (x == 11'd0) && (y == 11'd0);
  assign w_tick      = w_origin && !r_at_origin;
  assign w_step_eff  = (r_step == 8'd0) ? 8'd1 : r_step;
  assign w_step_done = ({1'b0, r_cnt} + 9'd1) >= {1'b0, w_step_eff};
  assign w_lvl_wr    = (wr_data[LW-1:0] > L_FULL) ? L_FULL : wr_data[LW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_lvl_nxt   = r_lvl;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    w_en_nxt    = r_en;
    if (w_wr) begin
      // A register write wins over a coincident tick, which is dropped.
      case (addr[1:0])
        2'd0: begin
          w_en_nxt = wr_data[0];
          if (wr_data[2]) begin
            w_state_nxt = S_FADE_IN;
            w_cnt_nxt   = 8'd0;
          end else if (wr_data[1]) begin
            w_state_nxt = S_FADE_OUT;
            w_cnt_nxt   = 8'd0;
          end
        end
        2'd1: w_step_nxt = wr_data[7:0];
        2'd2: begin
          w_lvl_nxt   = w_lvl_wr;
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 8'd0;
        end
        default: ;
      endcase
    end else if (w_tick) begin
      case (r_state)
        S_FADE_OUT: begin
          if (r_lvl == '0) begin
            w_state_nxt = S_HOLD;
          end else if (w_step_done) begin
            w_cnt_nxt = 8'd0;
            w_lvl_nxt = r_lvl - LW'(1);
            if (r_lvl == LW'(1)) w_state_nxt = S_HOLD;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        S_FADE_IN: begin
          if (r_lvl == L_FULL) begin
            w_state_nxt = S_HOLD;
          end else if (w_step_done) begin
            w_cnt_nxt = 8'd0;
            w_lvl_nxt = r_lvl + LW'(1);
            if (r_lvl == L_FULL - LW'(1)) w_state_nxt = S_HOLD;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [PW-1:0] w_prod;
    assign w_prod = PW'(r_s1_rgb[i*CW +: CW]) * PW'(r_s1_lvl);
    assign w_scaled[i*CW +: CW] = CW'(w_prod >> SH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_HOLD;
      r_lvl       <= L_FULL;
      r_cnt       <= 8'd0;
      r_step      <= 8'd1;
      r_en        <= 1'b0;
      r_at_origin <= 1'b1;
      r_tick_q    <= 1'b0;
      r_s1_rgb    <= '0;
      r_s1_lvl    <= '0;
      so_rgb      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lvl       <= w_lvl_nxt;
      r_cnt       <= w_cnt_nxt;
      r_step      <= w_step_nxt;
      r_en        <= w_en_nxt;
      r_at_origin <= w_origin;
      r_tick_q    <= w_tick;
      r_s1_rgb    <= si_rgb;
      // Disabled fader feeds unity gain into the multiplier: exact passthrough.
      r_s1_lvl    <= r_en ? r_lvl : L_FULL;
      so_rgb      <= w_scaled;
    end
  end

  assign o_dbg_state = r_state;
  assign o_dbg_level = r_lvl;
  assign o_dbg_tick  = r_tick_q;

endmodule
